// File: rtl/mac_rx_frame_parser_if.sv
// GMII receive byte stream in, parsed payload stream and CRC verdict out.
// The parser is the master of the payload stream.
interface mac_rx_frame_parser_if;
   logic [7:0]  i_gmii_data;
   logic        i_gmii_dv;
   logic [15:0] o_mac_type;
   logic [7:0]  o_mac_data;
   logic        o_mac_valid;
   logic        o_mac_last;
   logic        o_crc_valid;
   logic        o_crc_error;

   modport master (
      input  i_gmii_data,
      input  i_gmii_dv,
      output o_mac_type,
      output o_mac_data,
      output o_mac_valid,
      output o_mac_last,
      output o_crc_valid,
      output o_crc_error
   );

   modport slave (
      output i_gmii_data,
      output i_gmii_dv,
      input  o_mac_type,
      input  o_mac_data,
      input  o_mac_valid,
      input  o_mac_last,
      input  o_crc_valid,
      input  o_crc_error
   );
endinterface

// File: rtl/mac_rx_frame_parser.sv
// Ethernet rx front end: strips preamble/SFD, filters on destination MAC,
// extracts EtherType, checks CRC32 and forwards the payload with FCS removed.
module mac_rx_frame_parser #(
   parameter logic [47:0] P_LOCAL_MAC    = 48'h00_0A_35_01_FE_C0,
   parameter bit          P_ACCEPT_BCAST = 1'b1,
   parameter int          P_MAX_PAYLOAD  = 1500
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   mac_rx_frame_parser_if.master bus
);

   localparam int          W       = $clog2(P_MAX_PAYLOAD + 1);
   localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      HEADER,
      PAYLOAD,
      DROP,
      END
   } state_t;

   state_t         state;
   logic [7:0]     d_r;
   logic           dv_r;
   logic           dv_p;
   logic           armed;
   logic [2:0]     pre_cnt;
   logic [3:0]     hdr_cnt;
   logic [2:0]     fill;
   logic [W-1:0]   out_cnt;
   logic           oversize;
   logic           m_local;
   logic           m_bcast;
   logic [7:0]     type_hi;
   logic [31:0]    crc;
   logic [31:0]    crc_next;
   logic [7:0]     dl [0:4];
   logic [7:0]     mac_b;
   logic           hit_local;
   logic           hit_bcast;
   logic           start;
   logic           room;

   function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                           input logic [7:0]  d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   always_comb begin
      mac_b = 8'h00;
      case (hdr_cnt)
         4'd0:    mac_b = P_LOCAL_MAC[47:40];
         4'd1:    mac_b = P_LOCAL_MAC[39:32];
         4'd2:    mac_b = P_LOCAL_MAC[31:24];
         4'd3:    mac_b = P_LOCAL_MAC[23:16];
         4'd4:    mac_b = P_LOCAL_MAC[15:8];
         4'd5:    mac_b = P_LOCAL_MAC[7:0];
         default: mac_b = 8'h00;
      endcase
   end

   assign crc_next  = crc_upd(crc, d_r);
   assign hit_local = m_local && (d_r == mac_b);
   assign hit_bcast = m_bcast && (d_r == 8'hFF);
   // armed blocks a false start when reset releases mid-frame
   assign start     = armed && dv_r && !dv_p;
   assign room      = out_cnt < W'(P_MAX_PAYLOAD);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state           <= IDLE;
         d_r             <= '0;
         dv_r            <= 1'b0;
         dv_p            <= 1'b0;
         armed           <= 1'b0;
         pre_cnt         <= '0;
         hdr_cnt         <= '0;
         fill            <= '0;
         out_cnt         <= '0;
         oversize        <= 1'b0;
         m_local         <= 1'b0;
         m_bcast         <= 1'b0;
         type_hi         <= '0;
         crc             <= '1;
         for (int i = 0; i < 5; i++)
            dl[i] <= '0;
         bus.o_mac_type  <= '0;
         bus.o_mac_data  <= '0;
         bus.o_mac_valid <= 1'b0;
         bus.o_mac_last  <= 1'b0;
         bus.o_crc_valid <= 1'b0;
         bus.o_crc_error <= 1'b0;
      end else begin
         d_r  <= bus.i_gmii_data;
         dv_r <= bus.i_gmii_dv;
         dv_p <= dv_r;
         if (!dv_r)
            armed <= 1'b1;
         bus.o_mac_valid <= 1'b0;
         bus.o_mac_last  <= 1'b0;
         bus.o_crc_valid <= 1'b0;
         bus.o_crc_error <= 1'b0;
         case (state)
            // END doubles as IDLE so a 1-cycle IFG is not missed
            IDLE, END: begin
               state <= IDLE;
               if (start) begin
                  if (d_r == 8'h55) begin
                     state   <= PREAMBLE;
                     pre_cnt <= 3'd1;
                  end else begin
                     state <= DROP;
                  end
               end
            end
            PREAMBLE: begin
               if (!dv_r) begin
                  state <= IDLE;
               end else if (d_r == 8'h55 && pre_cnt != 3'd7) begin
                  pre_cnt <= pre_cnt + 3'd1;
               end else if (d_r == 8'hD5 && pre_cnt == 3'd7) begin
                  state   <= HEADER;
                  crc     <= '1;
                  hdr_cnt <= '0;
                  m_local <= 1'b1;
                  m_bcast <= P_ACCEPT_BCAST;
               end else begin
                  state <= DROP;
               end
            end
            HEADER: begin
               if (!dv_r) begin
                  state <= IDLE;
               end else begin
                  crc     <= crc_next;
                  hdr_cnt <= hdr_cnt + 4'd1;
                  if (hdr_cnt < 4'd6) begin
                     m_local <= hit_local;
                     m_bcast <= hit_bcast;
                  end
                  if (hdr_cnt == 4'd5 && !hit_local && !hit_bcast)
                     state <= DROP;
                  if (hdr_cnt == 4'd12)
                     type_hi <= d_r;
                  if (hdr_cnt == 4'd13) begin
                     bus.o_mac_type <= {type_hi, d_r};
                     state          <= PAYLOAD;
                     fill           <= '0;
                     out_cnt        <= '0;
                     oversize       <= 1'b0;
                  end
               end
            end
            PAYLOAD: begin
               if (dv_r) begin
                  crc   <= crc_next;
                  dl[0] <= d_r;
                  for (int i = 1; i < 5; i++)
                     dl[i] <= dl[i-1];
                  if (fill != 3'd5) begin
                     fill <= fill + 3'd1;
                  end else if (room) begin
                     bus.o_mac_data  <= dl[4];
                     bus.o_mac_valid <= 1'b1;
                     out_cnt         <= out_cnt + W'(1);
                  end else begin
                     oversize <= 1'b1;
                  end
               end else if (fill == 3'd5) begin
                  // dl[3:0] hold the FCS and are discarded
                  if (room) begin
                     bus.o_mac_data  <= dl[4];
                     bus.o_mac_valid <= 1'b1;
                  end
                  bus.o_mac_last  <= 1'b1;
                  bus.o_crc_valid <= 1'b1;
                  bus.o_crc_error <= (crc != RESIDUE) || oversize || !room;
                  state           <= END;
               end else begin
                  state <= IDLE;
               end
            end
            DROP: begin
               if (!dv_r)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
